uart_bus_master: RTL and testbench

//  UART-driven initiator for the 4-bit-address peripheral bus. Receives command bytes on rxd,

---
 rtl/uart_bus_master_pkg.sv | 26 ++
 rtl/uart_bus_master_uart.sv | 106 ++++++++++
 rtl/uart_bus_master.sv | 152 +++++++++++++++
 tb/tb_uart_bus_master.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_bus_master_pkg.sv
// Shared opcodes, default reply bytes and FSM state type for the UART bus master.
package uart_bus_master_pkg;

  localparam logic [3:0] OP_READ  = 4'hA;
  localparam logic [3:0] OP_WRITE = 4'hB;

  localparam logic [7:0] ACK_BYTE_DEF = 8'h2B;
  localparam logic [7:0] NAK_BYTE_DEF = 8'h3F;

  typedef enum logic [2:0] {
    IDLE,
    GET_DATA,
    BUS_WR,
    BUS_RD,
    RD_WAIT,
    SEND,
    SEND_HOLD
  } state_t;

  // States in which an incoming rx byte has nowhere to go.
  function automatic logic rx_dropped(input state_t s);
    return (s == BUS_WR) || (s == BUS_RD) || (s == RD_WAIT) ||
           (s == SEND)   || (s == SEND_HOLD);
  endfunction

endpackage

// File: rtl/uart_bus_master_uart.sv
// 8N1 UART receiver and transmitter sharing one baud divider setting.
module uart_bus_master_uart #(
  parameter int unsigned ClkFreq = 1000000,
  parameter int unsigned Baud    = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       rx_ready,
  output logic [7:0] rx_data,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       txd,
  output logic       tx_busy
);

  localparam int unsigned Div = ClkFreq / Baud;
  localparam int unsigned CW  = (Div > 2) ? $clog2(Div) : 1;
  localparam logic [CW-1:0] FULL = CW'(Div - 1);
  localparam logic [CW-1:0] HALF = CW'(Div / 2);

  logic          rx_s1, rx_s2, rx_act, rx_ready_q;
  logic [3:0]    rx_bit;
  logic [CW-1:0] rx_cnt;
  logic [7:0]    rx_sh, rx_data_q;

  logic          tx_act, txd_q;
  logic [3:0]    tx_bit;
  logic [CW-1:0] tx_cnt;
  logic [8:0]    tx_sh;

  // Bit 0 is the start bit re-check, bits 1..8 data, bit 9 the stop bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_act     <= 1'b0;
      rx_bit     <= '0;
      rx_cnt     <= '0;
      rx_sh      <= '0;
      rx_ready_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      rx_s1      <= rxd;
      rx_s2      <= rx_s1;
      rx_ready_q <= 1'b0;
      if (!rx_act) begin
        if (!rx_s2) begin
          rx_act <= 1'b1;
          rx_cnt <= HALF;
          rx_bit <= '0;
        end
      end else if (rx_cnt != '0) begin
        rx_cnt <= rx_cnt - 1'b1;
      end else begin
        rx_cnt <= FULL;
        rx_bit <= rx_bit + 1'b1;
        if (rx_bit == 4'd0) begin
          if (rx_s2) rx_act <= 1'b0;
        end else if (rx_bit == 4'd9) begin
          rx_act <= 1'b0;
          if (rx_s2) begin
            rx_ready_q <= 1'b1;
            rx_data_q  <= rx_sh;
          end
        end else begin
          rx_sh <= {rx_s2, rx_sh[7:1]};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_act <= 1'b0;
      tx_bit <= '0;
      tx_cnt <= '0;
      tx_sh  <= '1;
      txd_q  <= 1'b1;
    end else if (!tx_act) begin
      if (tx_start) begin
        tx_act <= 1'b1;
        tx_sh  <= {1'b1, tx_data};
        txd_q  <= 1'b0;
        tx_cnt <= FULL;
        tx_bit <= '0;
      end
    end else if (tx_cnt != '0) begin
      tx_cnt <= tx_cnt - 1'b1;
    end else if (tx_bit == 4'd9) begin
      tx_act <= 1'b0;
      txd_q  <= 1'b1;
    end else begin
      tx_cnt <= FULL;
      tx_bit <= tx_bit + 1'b1;
      txd_q  <= tx_sh[0];
      tx_sh  <= {1'b1, tx_sh[8:1]};
    end
  end

  assign rx_ready = rx_ready_q;
  assign rx_data  = rx_data_q;
  assign txd      = txd_q;
  assign tx_busy  = tx_act;

endmodule

// File: rtl/uart_bus_master.sv
// UART-driven initiator for the 4-bit-address peripheral bus: one read or write
// per command byte, answered with the read data, an ACK or a NAK.
module uart_bus_master
  import uart_bus_master_pkg::*;
#(
  parameter int unsigned ClkFreq       = 1000000,
  parameter int unsigned Baud          = 9600,
  parameter int unsigned TimeoutCycles = 100000,
  parameter int unsigned ReadLatency   = 1,
  parameter logic [7:0]  AckByte       = ACK_BYTE_DEF,
  parameter logic [7:0]  NakByte       = NAK_BYTE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       txd,
  output logic [3:0] bus_addr,
  output logic [7:0] bus_wdata,
  input  logic [7:0] bus_rdata,
  output logic       bus_rw,
  output logic       bus_cs,
  output logic       busy,
  output logic       err_ovr
);

  localparam int unsigned TW = $clog2(TimeoutCycles + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TimeoutCycles - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TimeoutCycles);
  localparam logic [1:0]    LAT_LAST = 2'(ReadLatency - 1);

  logic       rx_ready, tx_start, tx_busy;
  logic [7:0] rx_data;

  state_t        state_q, state_d;
  logic [3:0]    addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d, reply_q, reply_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    lat_q, lat_d;
  logic          cs_q, cs_d, rw_q, rw_d, err_q, err_d;

  uart_bus_master_uart #(
    .ClkFreq(ClkFreq),
    .Baud   (Baud)
  ) u_uart (
    .clk     (clk),
    .rst     (rst),
    .rxd     (rxd),
    .rx_ready(rx_ready),
    .rx_data (rx_data),
    .tx_start(tx_start),
    .tx_data (reply_q),
    .txd     (txd),
    .tx_busy (tx_busy)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    reply_d  = reply_q;
    timer_d  = timer_q;
    lat_d    = lat_q;
    tx_start = 1'b0;
    err_d    = rx_ready && rx_dropped(state_q);
    unique case (state_q)
      IDLE: begin
        if (rx_ready) begin
          addr_d = rx_data[3:0];
          if (rx_data[7:4] == OP_READ) begin
            state_d = BUS_RD;
          end else if (rx_data[7:4] == OP_WRITE) begin
            state_d = GET_DATA;
            timer_d = '0;
          end else begin
            reply_d = NakByte;
            state_d = SEND;
          end
        end
      end
      GET_DATA: begin
        // A byte landing on the timeout cycle still completes the write.
        if (rx_ready) begin
          wdata_d = rx_data;
          state_d = BUS_WR;
        end else if (timer_q == TMO_LAST) begin
          state_d = IDLE;
        end else if (timer_q < TMO_MAX) begin
          timer_d = timer_q + 1'b1;
        end
      end
      BUS_WR: begin
        reply_d = AckByte;
        state_d = SEND;
      end
      BUS_RD: begin
        lat_d   = '0;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (lat_q == LAT_LAST) begin
          reply_d = bus_rdata;
          state_d = SEND;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_d  = SEND_HOLD;
        end
      end
      SEND_HOLD: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    // Strobes are computed from the next state so they register aligned with BUS_*.
    cs_d = (state_d == BUS_WR) || (state_d == BUS_RD);
    rw_d = (state_d != BUS_WR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      reply_q <= '0;
      timer_q <= '0;
      lat_q   <= '0;
      cs_q    <= 1'b0;
      rw_q    <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      reply_q <= reply_d;
      timer_q <= timer_d;
      lat_q   <= lat_d;
      cs_q    <= cs_d;
      rw_q    <= rw_d;
      err_q   <= err_d;
    end
  end

  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_cs    = cs_q;
  assign bus_rw    = rw_q;
  assign busy      = (state_q != IDLE);
  assign err_ovr   = err_q;

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench: serial host driver, txd frame decoder and a registered-read slave.
module tb_uart_bus_master;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic       txd;
  logic [3:0] bus_addr;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata;
  logic       bus_rw, bus_cs, busy, err_ovr;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] rep [0:255];
  int         rep_n = 0;
  int         rep_rd = 0;

  int         cs_n = 0;
  int         err_n = 0;
  int         cs_run = 0;
  logic       prev_cs = 1'b0;
  logic       last_rw = 1'b1;
  logic [3:0] last_addr = '0;
  logic [7:0] last_wdata = '0;

  always #5 clk = ~clk;

  uart_bus_master #(
    .ClkFreq      (1000000),
    .Baud         (100000),
    .TimeoutCycles(400),
    .ReadLatency  (1),
    .AckByte      (8'h2B),
    .NakByte      (8'h3F)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rxd),
    .txd      (txd),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .bus_rw   (bus_rw),
    .bus_cs   (bus_cs),
    .busy     (busy),
    .err_ovr  (err_ovr)
  );

  function automatic logic [7:0] slave_reg(input logic [3:0] a);
    case (a)
      4'h1:    return 8'h11;
      4'h2:    return 8'h69;
      4'h4:    return 8'hC3;
      default: return {a, ~a};
    endcase
  endfunction

  // Read data is valid only in the cycle after the cs strobe.
  always @(posedge clk) bus_rdata <= (bus_cs && bus_rw) ? slave_reg(bus_addr) : 8'hEE;

  initial begin
    @(negedge rst);
    forever begin
      @(negedge clk);
      if (bus_cs) begin
        cs_n++;
        last_rw    = bus_rw;
        last_addr  = bus_addr;
        last_wdata = bus_wdata;
        if (prev_cs) cs_run++;
      end
      prev_cs = bus_cs;
      if (err_ovr) err_n++;
    end
  end

  initial begin
    logic [7:0] d;
    d = '0;
    @(negedge rst);
    forever begin
      @(negedge clk);
      if (txd === 1'b0) begin
        repeat (5) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (10) @(negedge clk);
          d[i] = txd;
        end
        repeat (10) @(negedge clk);
        if (rep_n < 256) rep[rep_n] = d;
        rep_n++;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rxd = 1'b0;
    tick(10);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(10);
    end
    rxd = 1'b1;
    tick(10);
  endtask

  task automatic expect_reply(input string tag, input logic [7:0] exp);
    int n;
    logic [31:0] got;
    n = 0;
    while (rep_n <= rep_rd && n < 3000) begin
      tick(1);
      n++;
    end
    got = (rep_n > rep_rd) ? {24'h0, rep[rep_rd]} : 32'h100;
    check_eq(tag, got, {24'h0, exp});
    if (rep_n > rep_rd) rep_rd++;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 20000) begin
      tick(1);
      n++;
    end
    check_eq(tag, busy, 0);
  endtask

  initial begin
    int cs0, err0, sent;

    tick(3);
    check_eq("rst_txd",   txd, 1);
    check_eq("rst_cs",    bus_cs, 0);
    check_eq("rst_rw",    bus_rw, 1);
    check_eq("rst_addr",  bus_addr, 0);
    check_eq("rst_wdata", bus_wdata, 0);
    check_eq("rst_busy",  busy, 0);
    check_eq("rst_err",   err_ovr, 0);
    rst = 1'b0;
    tick(5);

    cs0 = cs_n;
    send_byte(8'hB0);
    send_byte(8'h5A);
    expect_reply("wr_ack", 8'h2B);
    check_eq("wr_cs_count", cs_n - cs0, 1);
    check_eq("wr_rw",       last_rw, 0);
    check_eq("wr_addr",     last_addr, 4'h0);
    check_eq("wr_wdata",    last_wdata, 8'h5A);
    wait_idle("wr_idle");
    check_eq("wr_wdata_hold", bus_wdata, 8'h5A);
    tick(150);

    cs0 = cs_n;
    send_byte(8'hA4);
    expect_reply("rd4_data", 8'hC3);
    check_eq("rd4_cs_count", cs_n - cs0, 1);
    check_eq("rd4_rw",       last_rw, 1);
    check_eq("rd4_addr",     last_addr, 4'h4);
    tick(150);

    cs0 = cs_n;
    send_byte(8'h17);
    expect_reply("bad_nak", 8'h3F);
    check_eq("bad_cs_count", cs_n - cs0, 0);
    wait_idle("bad_idle");
    tick(150);

    cs0 = cs_n;
    send_byte(8'hB2);
    tick(1);
    check_eq("tmo_busy_start", busy, 1);
    tick(370);
    check_eq("tmo_busy_before", busy, 1);
    tick(60);
    check_eq("tmo_busy_after", busy, 0);
    check_eq("tmo_cs_count", cs_n - cs0, 0);
    tick(150);
    check_eq("tmo_no_reply", rep_n - rep_rd, 0);

    cs0 = cs_n;
    send_byte(8'hA2);
    expect_reply("rd2_data", 8'h69);
    check_eq("rd2_cs_count", cs_n - cs0, 1);
    check_eq("rd2_addr",     last_addr, 4'h2);
    tick(150);

    // Back-to-back commands outrun the transmitter until one lands in SEND.
    cs0  = cs_n;
    err0 = err_n;
    sent = 0;
    send_byte(8'hA1);
    while (err_n == err0 && sent < 150) begin
      send_byte(8'h17);
      sent++;
    end
    wait_idle("ovr_idle");
    tick(250);
    check_eq("ovr_pulses", err_n - err0, 1);
    expect_reply("ovr_first", 8'h11);
    check_eq("ovr_reply_count", rep_n - rep_rd, sent - 1);
    check_eq("ovr_last_nak", (rep_n > 0) ? rep[(rep_n - 1) % 256] : 8'h00, 8'h3F);
    check_eq("ovr_cs_count", cs_n - cs0, 1);
    rep_rd = rep_n;

    cs0 = cs_n;
    send_byte(8'hB5);
    check_eq("rstg_busy_before", busy, 1);
    rst = 1'b1;
    tick(1);
    check_eq("rstg_busy",  busy, 0);
    check_eq("rstg_cs",    bus_cs, 0);
    check_eq("rstg_rw",    bus_rw, 1);
    check_eq("rstg_addr",  bus_addr, 0);
    check_eq("rstg_wdata", bus_wdata, 0);
    check_eq("rstg_txd",   txd, 1);
    rst = 1'b0;
    tick(3);
    send_byte(8'h77);
    expect_reply("rstg_data_as_cmd", 8'h3F);
    check_eq("rstg_cs_count", cs_n - cs0, 0);
    check_eq("rstg_wdata_after", bus_wdata, 0);
    wait_idle("rstg_idle");
    tick(150);

    check_eq("cs_single_cycle", cs_run, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
